// File: rtl/rx_desc_scheduler_pkg.sv
// Shared types and helpers for the RX descriptor scheduler.
package rx_sched_pkg;

   localparam int META_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      START,
      WAIT_DONE,
      COMPLETE
   } sched_state_e;

   function automatic logic [31:0] slot_addr(input logic [31:0] base,
                                             input logic [31:0] slot,
                                             input int unsigned shift);
      return base + (slot << shift);
   endfunction

endpackage

// File: rtl/rx_desc_scheduler_irq_coalescer.sv
// Interrupt coalescer: fires after IRQ_THRESH completions or IRQ_TMO cycles
// after the first pending completion, whichever comes first.
module irq_coalescer #(
   parameter int IRQ_THRESH = 4,
   parameter int IRQ_TMO    = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_cpl_valid,
   output logic o_irq
);

   logic [15:0] pend_q, pend_d;
   logic [31:0] tmo_q, tmo_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         tmo_q  <= '0;
      end else begin
         pend_q <= pend_d;
         tmo_q  <= tmo_d;
      end
   end

   always_comb begin
      o_irq = (pend_q >= 16'(IRQ_THRESH)) ||
              ((pend_q != '0) && (tmo_q >= 32'(IRQ_TMO)));
      // a completion landing on the irq cycle starts the next batch
      if (o_irq) begin
         pend_d = {15'd0, i_cpl_valid};
         tmo_d  = {31'd0, i_cpl_valid};
      end else begin
         pend_d = pend_q + {15'd0, i_cpl_valid};
         tmo_d  = ((pend_q != '0) || i_cpl_valid) ? tmo_q + 32'd1 : '0;
      end
   end

endmodule

// File: rtl/rx_desc_scheduler.sv
// RX descriptor scheduler: pops length descriptors, assigns ring slots,
// drives the DMA engine and publishes completions.
//   state     | meaning
//   IDLE      | wait for enable, descriptor and a free slot
//   CHECK     | pop descriptor, drop if length invalid
//   START     | one-cycle DMA start pulse
//   WAIT_DONE | wait for DMA done, watchdog running
//   COMPLETE  | completion strobe, advance producer index
module rx_desc_scheduler
   import rx_sched_pkg::*;
#(
   parameter int SLOT_BITS  = 4,
   parameter int SLOT_SHIFT = 11,
   parameter int IRQ_THRESH = 4,
   parameter int IRQ_TMO    = 1024,
   parameter int DONE_TMO   = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_enable,
   input  logic [31:0]          i_ring_base,
   input  logic [SLOT_BITS:0]   i_host_cons_idx,
   input  logic [META_W-1:0]    i_meta_data,
   input  logic                 i_meta_empty,
   output logic                 o_meta_ren,
   output logic                 o_dma_start,
   output logic [31:0]          o_dma_base_addr,
   output logic [31:0]          o_dma_len,
   input  logic                 i_dma_done,
   output logic [SLOT_BITS:0]   o_prod_idx,
   output logic                 o_cpl_valid,
   output logic [SLOT_BITS-1:0] o_cpl_slot,
   output logic [META_W-1:0]    o_cpl_len,
   output logic                 o_irq,
   output logic [31:0]          o_drop_cnt,
   output logic                 o_timeout
);

   localparam int IDX_W = SLOT_BITS + 1;
   localparam logic [IDX_W-1:0] FULL_DIFF = IDX_W'(1) << SLOT_BITS;
   localparam logic [31:0]      MAX_LEN   = 32'(1) << SLOT_SHIFT;
   localparam logic [31:0]      WD_LIMIT  = 32'(DONE_TMO);

   sched_state_e        state_q, state_d;
   logic [IDX_W-1:0]    prod_idx_q, prod_idx_d;
   logic [META_W-1:0]   len_q, len_d;
   logic [31:0]         dma_base_q, dma_base_d;
   logic [15:0]         dma_len_q, dma_len_d;
   logic [31:0]         drop_cnt_q, drop_cnt_d;
   logic [31:0]         wd_q, wd_d;
   logic                timeout_q, timeout_d;
   logic                ring_full, meta_bad, cpl_valid;
   logic [15:0]         len_rnd;

   assign ring_full = (prod_idx_q - i_host_cons_idx) == FULL_DIFF;
   assign meta_bad  = (i_meta_data == '0) || (32'(i_meta_data) > MAX_LEN);
   assign len_rnd   = (i_meta_data + 16'd3) & ~16'd3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prod_idx_q <= '0;
         len_q      <= '0;
         dma_base_q <= '0;
         dma_len_q  <= '0;
         drop_cnt_q <= '0;
         wd_q       <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prod_idx_q <= prod_idx_d;
         len_q      <= len_d;
         dma_base_q <= dma_base_d;
         dma_len_q  <= dma_len_d;
         drop_cnt_q <= drop_cnt_d;
         wd_q       <= wd_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (i_enable && !i_meta_empty && !ring_full) state_d = CHECK;
         CHECK:     state_d = meta_bad ? IDLE : START;
         START:     state_d = WAIT_DONE;
         WAIT_DONE: if (i_dma_done) state_d = COMPLETE;
         COMPLETE:  state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      prod_idx_d = prod_idx_q;
      len_d      = len_q;
      dma_base_d = dma_base_q;
      dma_len_d  = dma_len_q;
      drop_cnt_d = drop_cnt_q;
      wd_d       = '0;
      timeout_d  = timeout_q;
      if (state_q == CHECK) begin
         len_d = i_meta_data;
         if (meta_bad) begin
            if (drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
         end else begin
            dma_base_d = slot_addr(i_ring_base, 32'(prod_idx_q[SLOT_BITS-1:0]), SLOT_SHIFT);
            dma_len_d  = len_rnd;
         end
      end
      // watchdog only flags; the DMA is never aborted from here
      if (state_q == WAIT_DONE) begin
         wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 32'd1;
         if (wd_q == WD_LIMIT - 32'd1) timeout_d = 1'b1;
      end
      if (state_q == COMPLETE) prod_idx_d = prod_idx_q + IDX_W'(1);
   end

   always_comb begin
      o_meta_ren  = (state_q == CHECK);
      o_dma_start = (state_q == START);
      cpl_valid   = (state_q == COMPLETE);
      o_cpl_slot  = cpl_valid ? prod_idx_q[SLOT_BITS-1:0] : '0;
      o_cpl_len   = cpl_valid ? len_q : '0;
   end

   assign o_cpl_valid     = cpl_valid;
   assign o_dma_base_addr = dma_base_q;
   assign o_dma_len       = {16'b0, dma_len_q};
   assign o_prod_idx      = prod_idx_q;
   assign o_drop_cnt      = drop_cnt_q;
   assign o_timeout       = timeout_q;

   irq_coalescer #(
      .IRQ_THRESH (IRQ_THRESH),
      .IRQ_TMO    (IRQ_TMO)
   ) u_irq (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cpl_valid (cpl_valid),
      .o_irq       (o_irq)
   );

endmodule

// File: tb/tb_rx_desc_scheduler.sv
// Directed bench for rx_desc_scheduler with a hand-driven FIFO and DMA.
module tb_rx_desc_scheduler;

   localparam int DONE_TMO = 300;
   localparam int IRQ_TMO  = 1024;
   localparam logic [31:0] RB = 32'h1000_0000;

   logic        clk, rst_n, i_enable, i_meta_empty, i_dma_done;
   logic [31:0] i_ring_base;
   logic [4:0]  i_host_cons_idx;
   logic [15:0] i_meta_data;
   logic        o_meta_ren, o_dma_start, o_cpl_valid, o_irq, o_timeout;
   logic [31:0] o_dma_base_addr, o_dma_len, o_drop_cnt;
   logic [4:0]  o_prod_idx;
   logic [3:0]  o_cpl_slot;
   logic [15:0] o_cpl_len;

   int n_chk = 0, n_err = 0;
   int cyc = 0, n_start = 0, n_ren = 0, n_cpl = 0, n_irq = 0, cpl_cyc = 0, irq_cyc = 0;

   rx_desc_scheduler #(.DONE_TMO(DONE_TMO), .IRQ_TMO(IRQ_TMO)) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_ring_base(i_ring_base),
      .i_host_cons_idx(i_host_cons_idx), .i_meta_data(i_meta_data),
      .i_meta_empty(i_meta_empty), .o_meta_ren(o_meta_ren), .o_dma_start(o_dma_start),
      .o_dma_base_addr(o_dma_base_addr), .o_dma_len(o_dma_len), .i_dma_done(i_dma_done),
      .o_prod_idx(o_prod_idx), .o_cpl_valid(o_cpl_valid), .o_cpl_slot(o_cpl_slot),
      .o_cpl_len(o_cpl_len), .o_irq(o_irq), .o_drop_cnt(o_drop_cnt), .o_timeout(o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (o_dma_start) n_start++;
      if (o_meta_ren)  n_ren++;
      if (o_cpl_valid) begin n_cpl++; cpl_cyc = cyc; end
      if (o_irq)       begin n_irq++; irq_cyc = cyc; end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return o_meta_ren;
         1:       return o_dma_start;
         2:       return o_cpl_valid;
         default: return o_irq;
      endcase
   endfunction

   task automatic wait_sig(input int w, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (sig(w)) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic do_packet(input logic [15:0] len, input logic [31:0] exp_base,
                            input logic [31:0] exp_len, input int slot, input bit give_done);
      bit ok;
      i_meta_data  = len;
      i_meta_empty = 1'b0;
      wait_sig(0, 20, ok);
      chk("pop", 32'(ok), 1);
      i_meta_empty = 1'b1;
      wait_sig(1, 10, ok);
      chk("start", 32'(ok), 1);
      chk("dma_base", o_dma_base_addr, exp_base);
      chk("dma_len", o_dma_len, exp_len);
      if (give_done) begin
         repeat (3) @(negedge clk);
         i_dma_done = 1'b1;
         @(negedge clk);
         i_dma_done = 1'b0;
         wait_sig(2, 5, ok);
         chk("cpl", 32'(ok), 1);
         chk("cpl_slot", 32'(o_cpl_slot), 32'(slot));
         chk("cpl_len", 32'(o_cpl_len), 32'(len));
         @(negedge clk);
      end
   endtask

   task automatic do_drop(input logic [15:0] len);
      bit ok;
      i_meta_data  = len;
      i_meta_empty = 1'b0;
      wait_sig(0, 20, ok);
      chk("drop_pop", 32'(ok), 1);
      i_meta_empty = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int s;
      bit ok;
      rst_n = 1'b0; i_enable = 1'b1; i_ring_base = RB; i_host_cons_idx = '0;
      i_meta_data = '0; i_meta_empty = 1'b1; i_dma_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {27'd0, o_meta_ren, o_dma_start, o_cpl_valid, o_irq, o_timeout}, 0);
      chk("rst_prod", 32'(o_prod_idx), 0);
      chk("rst_base", o_dma_base_addr, 0);
      chk("rst_drop", o_drop_cnt, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      do_packet(16'd100, RB, 32'd100, 0, 1'b1);
      chk("prod_1", 32'(o_prod_idx), 1);
      do_packet(16'd4, RB + 32'h800, 32'd4, 1, 1'b1);
      do_packet(16'd2048, RB + 32'h1000, 32'd2048, 2, 1'b1);
      do_packet(16'd61, RB + 32'h1800, 32'd64, 3, 1'b1);
      chk("prod_4", 32'(o_prod_idx), 4);

      s = n_start;
      do_drop(16'd0);
      do_drop(16'd3000);
      chk("drop_2", o_drop_cnt, 2);
      do_drop(16'd2049);
      chk("drop_3", o_drop_cnt, 3);
      chk("drop_nostart", 32'(n_start - s), 0);
      chk("drop_prod", 32'(o_prod_idx), 4);

      for (int k = 4; k < 16; k++)
         do_packet(16'(8 * k + 1), RB + 32'(k) * 32'h800, 32'(8 * k + 4), k, 1'b1);
      chk("prod_16", 32'(o_prod_idx), 16);
      s = n_ren;
      i_meta_data = 16'd33; i_meta_empty = 1'b0;
      repeat (20) @(negedge clk);
      chk("full_nopop", 32'(n_ren - s), 0);
      i_host_cons_idx = 5'd1;
      do_packet(16'd33, RB, 32'd36, 0, 1'b1);
      chk("prod_17", 32'(o_prod_idx), 17);

      do_reset();
      i_host_cons_idx = '0;
      s = n_irq;
      for (int k = 0; k < 3; k++)
         do_packet(16'd16, RB + 32'(k) * 32'h800, 32'd16, k, 1'b1);
      chk("irq_early", 32'(n_irq - s), 0);
      do_packet(16'd16, RB + 32'h1800, 32'd16, 3, 1'b1);
      repeat (3) @(negedge clk);
      chk("irq_thresh", 32'(n_irq - s), 1);

      do_packet(16'd10, RB + 32'h2000, 32'd12, 4, 1'b1);
      wait_sig(3, IRQ_TMO + 100, ok);
      chk("irq_tmo_seen", 32'(ok), 1);
      repeat (2) @(negedge clk);
      chk("irq_tmo_delay", 32'(irq_cyc - cpl_cyc), IRQ_TMO);

      s = n_cpl;
      i_dma_done = 1'b1;
      @(negedge clk);
      i_dma_done = 1'b0;
      repeat (4) @(negedge clk);
      chk("done_ignored", 32'(n_cpl - s), 0);
      do_drop(16'd5000);

      i_meta_data = 16'd200; i_meta_empty = 1'b0;
      wait_sig(0, 20, ok);
      i_meta_empty = 1'b1;
      wait_sig(1, 10, ok);
      chk("en_start", 32'(ok), 1);
      i_enable = 1'b0;
      i_meta_data = 16'd300; i_meta_empty = 1'b0;
      repeat (3) @(negedge clk);
      i_dma_done = 1'b1;
      @(negedge clk);
      i_dma_done = 1'b0;
      wait_sig(2, 5, ok);
      chk("en_cpl_slot", ok ? 32'(o_cpl_slot) : 32'hDEAD, 5);
      @(negedge clk);
      s = n_ren;
      repeat (20) @(negedge clk);
      chk("en_parked", 32'(n_ren - s), 0);
      i_enable = 1'b1;
      do_packet(16'd300, RB + 32'h3000, 32'd300, 6, 1'b1);

      do_packet(16'd64, RB + 32'h3800, 32'd64, 7, 1'b0);
      repeat (DONE_TMO - 10) @(negedge clk);
      chk("tmo_before", 32'(o_timeout), 0);
      repeat (20) @(negedge clk);
      chk("tmo_after", 32'(o_timeout), 1);
      chk("tmo_prod", 32'(o_prod_idx), 7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctl", {27'd0, o_meta_ren, o_dma_start, o_cpl_valid, o_irq, o_timeout}, 0);
      chk("mid_rst_prod", 32'(o_prod_idx), 0);
      chk("mid_rst_drop", o_drop_cnt, 0);
      chk("mid_rst_base", o_dma_base_addr, 0);
      chk("mid_rst_len", o_dma_len, 0);
      chk("mid_rst_state", 32'(dut.state_q), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
